// File: rtl/unpack_sched_pkg.sv
// rtl/unpack_sched_pkg.sv - shared state type and sizing helpers for the unpack scheduler
package unpack_sched_pkg;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_e;

  function automatic int num_slices(input int in_w, input int out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with an optional sticky lock mask
// A requesting channel flagged in lock_hold wins outright; otherwise search upward from ptr.
module rr_arbiter
  import unpack_sched_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic [NUM_CH-1:0] lock_hold,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  logic              found;
  logic [CH_W-1:0]   cidx;
  logic [NUM_CH-1:0] lock_hit;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cidx     = '0;
    lock_hit = req & lock_hold;
    for (int i = 0; i < NUM_CH; i++) begin
      cidx = CH_W'(i);
      if (lock_hit[cidx] && !found) begin
        gnt[cidx] = 1'b1;
        gnt_idx   = cidx;
        found     = 1'b1;
      end
    end
    for (int o = 0; o < NUM_CH; o++) begin
      cidx = CH_W'((int'(ptr) + o) % NUM_CH);
      if (req[cidx] && !found) begin
        gnt[cidx] = 1'b1;
        gnt_idx   = cidx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unpack_rr_scheduler.sv
// rtl/unpack_rr_scheduler.sv - round-robin shared IN_WIDTH->OUT_WIDTH unpacker, MSB-first slices
// Optional UNPACK_SCHED_LOCK_EN adds in_lock: a locked grant re-wins the next arbitration.
module unpack_rr_scheduler
  import unpack_sched_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int IN_WIDTH  = 32,
  parameter  int OUT_WIDTH = 7,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          cfg_chan_en,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0] in_data,
`ifdef UNPACK_SCHED_LOCK_EN
  input  logic [NUM_CH-1:0]          in_lock,
`endif
  output logic [NUM_CH-1:0]          in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [CH_W-1:0]            out_chan,
  output logic                       first_packet,
  output logic                       last_packet,
  output logic                       busy
);

  localparam int NSL   = num_slices(IN_WIDTH, OUT_WIDTH);
  localparam int SH_W  = NSL * OUT_WIDTH;
  localparam int PAD   = SH_W - IN_WIDTH;
  localparam int CNT_W = ch_width(NSL);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] lock_mask_q, lock_mask_d;

  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic [NUM_CH-1:0]   lock_hold;
  logic [IN_WIDTH-1:0] word_sel;
  logic                fire;
  logic                last_slice;
  logic                can_arb;
  logic                take;
  logic [CH_W-1:0]     ptr_next;

  assign eligible   = in_valid & cfg_chan_en;
  assign busy       = (state_q == S_DRAIN);
  assign fire       = busy & out_ready;
  assign last_slice = (cnt_q == CNT_W'(NSL - 1));
  // Arbitration also runs on the last slice's handshake so words chain without a bubble.
  assign can_arb    = (state_q == S_IDLE) | (fire & last_slice);
  assign take       = can_arb & (|eligible);
  assign word_sel   = IN_WIDTH'(in_data >> (int'(gnt_idx) * IN_WIDTH));
  assign ptr_next   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef UNPACK_SCHED_LOCK_EN
  assign lock_hold = lock_mask_q;
`else
  assign lock_hold = '0;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr_q),
    .lock_hold (lock_hold),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    chan_d      = chan_q;
    ptr_d       = ptr_q;
    lock_mask_d = lock_mask_q;
    in_ready    = can_arb ? gnt : '0;

    if (fire) begin
      if (last_slice) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      shreg_d = shreg_q << OUT_WIDTH;
    end

    if (take) begin
      state_d = S_DRAIN;
      cnt_d   = '0;
      // Left-justify the word so the short final slice is zero-padded in its LSBs.
      shreg_d = SH_W'(word_sel) << PAD;
      chan_d  = gnt_idx;
`ifdef UNPACK_SCHED_LOCK_EN
      if (in_lock[gnt_idx]) begin
        lock_mask_d = gnt;
      end else begin
        lock_mask_d = '0;
        ptr_d       = ptr_next;
      end
`else
      ptr_d = ptr_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      chan_q      <= '0;
      ptr_q       <= '0;
      lock_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      chan_q      <= chan_d;
      ptr_q       <= ptr_d;
      lock_mask_q <= lock_mask_d;
    end
  end

  assign out_valid    = busy;
  assign out_data     = busy ? shreg_q[SH_W-1 -: OUT_WIDTH] : '0;
  assign out_chan     = chan_q;
  assign first_packet = busy & (cnt_q == '0);
  assign last_packet  = busy & last_slice;

endmodule

// File: tb/tb_unpack_rr_scheduler.sv
// tb/tb_unpack_rr_scheduler.sv - bench for unpack_rr_scheduler: queue-based sources, arithmetic model
// Build with UNPACK_SCHED_LOCK_EN defined to exercise the lock option.
module tb_unpack_rr_scheduler;

  localparam int NCH = 4;
  localparam int IW  = 32;
  localparam int OW  = 7;
  localparam int NSL = 5;
  localparam int R   = IW - (NSL - 1) * OW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     cfg_chan_en = 4'hF;
  logic [3:0]     in_valid = '0;
  logic [127:0]   in_data = '0;
  logic [3:0]     in_lock = '0;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [6:0]     out_data;
  logic [1:0]     out_chan;
  logic           first_packet, last_packet, busy;

  always #5 clk = ~clk;

  unpack_rr_scheduler #(.NUM_CH(4), .IN_WIDTH(32), .OUT_WIDTH(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_chan_en  (cfg_chan_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
`ifdef UNPACK_SCHED_LOCK_EN
    .in_lock      (in_lock),
`endif
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_chan     (out_chan),
    .first_packet (first_packet),
    .last_packet  (last_packet),
    .busy         (busy)
  );

  logic [31:0] srcq [NCH][$];
  bit          srcl [NCH][$];

  bit          m_busy;
  logic [31:0] m_word;
  int          m_k, m_ch, m_ptr, m_lock;

  logic [6:0]  obs_d [$];
  int          obs_c [$];
  bit          obs_f [$];
  bit          obs_l [$];
  int          dgr [$];
  int          mgr [$];
  int          cyc, valid_cnt, first_v, last_v, in1_cnt, hold37, hs_cyc, fv_cyc;
  int          total = 0;
  int          bad = 0;

  function automatic logic [6:0] slice_of(input logic [31:0] w, input int k);
    logic [31:0] t;
    if (k < NSL - 1) t = w >> (IW - (k + 1) * OW);
    else             t = (w & ((32'd1 << R) - 1)) << (OW - R);
    return t[6:0];
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      in_valid[i]           = (srcq[i].size() > 0);
      in_data[i*IW +: IW]   = (srcq[i].size() > 0) ? srcq[i][0] : 32'h0;
      in_lock[i]            = (srcl[i].size() > 0) ? srcl[i][0] : 1'b0;
    end
  endtask

  task automatic cycle();
    logic [3:0] elig, exp_rdy, pop;
    int win, lk, gi;
    bit can;
    @(negedge clk);
    cyc++;
    pop = '0;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_first", first_packet, 0);
      check("rst_last", last_packet, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_chan", out_chan, 0);
      m_busy = 0; m_k = 0; m_ch = 0; m_ptr = 0; m_lock = -1;
    end else begin
      elig = in_valid & cfg_chan_en;
      win = -1;
      can = !m_busy || (out_ready && m_k == NSL - 1);
      if (can && elig != 0) begin
        if (m_lock >= 0 && elig[m_lock]) win = m_lock;
        else for (int o = 0; o < NCH; o++) begin
          if (win < 0 && elig[(m_ptr + o) % NCH]) win = (m_ptr + o) % NCH;
        end
      end
      exp_rdy = (win >= 0) ? (4'd1 << win) : 4'd0;
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, m_busy);
      check("busy", busy, m_busy);
      check("first_packet", first_packet, m_busy && m_k == 0);
      check("last_packet", last_packet, m_busy && m_k == NSL - 1);
      if (m_busy) begin
        check("out_data", out_data, slice_of(m_word, m_k));
        check("out_chan", out_chan, m_ch);
      end
      if (out_valid && out_ready) begin
        obs_d.push_back(out_data); obs_c.push_back(out_chan);
        obs_f.push_back(first_packet); obs_l.push_back(last_packet);
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (fv_cyc < 0) fv_cyc = cyc;
        if (out_data == 7'h37) hold37++;
      end
      if (in_ready != 0) begin
        gi = 0;
        for (int i = 0; i < NCH; i++) if (in_ready[i]) gi = i;
        dgr.push_back(gi);
        if (hs_cyc < 0) hs_cyc = cyc;
      end
      if (in_ready[1]) in1_cnt++;
      pop = in_ready & in_valid;
      if (m_busy && out_ready) begin
        if (m_k == NSL - 1) m_busy = 0;
        else m_k++;
      end
      if (win >= 0) begin
        mgr.push_back(win);
        m_busy = 1; m_k = 0; m_ch = win;
        m_word = 32'(in_data >> (win * IW));
`ifdef UNPACK_SCHED_LOCK_EN
        lk = in_lock[win];
`else
        lk = 0;
`endif
        if (lk != 0) m_lock = win;
        else begin m_lock = -1; m_ptr = (win + 1) % NCH; end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (pop[i] && srcq[i].size() > 0) begin
        void'(srcq[i].pop_front());
        void'(srcl[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_c.delete(); obs_f.delete(); obs_l.delete();
    dgr.delete(); mgr.delete();
    valid_cnt = 0; first_v = -1; last_v = -1; in1_cnt = 0; hold37 = 0;
    hs_cyc = -1; fv_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) begin srcq[i].delete(); srcl[i].delete(); end
    drive();
    cycle(); cycle();
    rst_n = 1'b1;
    cfg_chan_en = 4'hF;
    out_ready = 1'b1;
    clear_obs();
  endtask

  task automatic push(input int ch, input logic [31:0] w, input bit lk);
    srcq[ch].push_back(w);
    srcl[ch].push_back(lk);
  endtask

  task automatic wait_obs(input int n, input int lim);
    for (int c = 0; c < lim && obs_d.size() < n; c++) cycle();
    check("wait_obs_timeout", obs_d.size() >= n, 1);
  endtask

  task automatic wait_grants(input int n, input int lim);
    for (int c = 0; c < lim && dgr.size() < n; c++) cycle();
    check("wait_grant_timeout", dgr.size() >= n, 1);
  endtask

  task automatic wait_idle(input int lim);
    for (int c = 0; c < lim && (busy || (in_valid & cfg_chan_en) != 0); c++) cycle();
    check("wait_idle_timeout", busy, 0);
  endtask

  task automatic check_seq(input string nm, input logic [6:0] e0, e1, e2, e3, e4, input int ch);
    logic [6:0] ev [5];
    ev = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++) begin
      if (i < obs_d.size()) begin
        check({nm, "_data"}, obs_d[i], ev[i]);
        check({nm, "_chan"}, obs_c[i], ch);
        check({nm, "_first"}, obs_f[i], i == 0);
        check({nm, "_last"}, obs_l[i], i == 4);
      end
    end
  endtask

  task automatic check_grants(input string nm, input int g0, g1, g2, g3);
    int eg [4];
    eg = '{g0, g1, g2, g3};
    for (int i = 0; i < 4; i++) begin
      if (i < dgr.size()) check({nm, "_dut_grant"}, dgr[i], eg[i]);
      if (i < mgr.size()) check({nm, "_model_grant"}, mgr[i], eg[i]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_busy = 0; m_k = 0; m_ch = 0; m_ptr = 0; m_lock = -1; cyc = 0;
    clear_obs();

    // reset state, then a single word drained at full rate
    do_reset();
    check("model_slice0_pin", slice_of(32'hDEADBEEF, 0), 7'h6F);
    check("model_slice4_pin", slice_of(32'hDEADBEEF, 4), 7'h78);
    push(0, 32'hDEADBEEF, 0);
    drive();
    wait_obs(5, 20);
    check_seq("t1", 7'h6F, 7'h2B, 7'h37, 7'h6E, 7'h78, 0);
    check("t1_latency", fv_cyc - hs_cyc, 1);
    wait_idle(20);

    // stall three cycles on slice 2 while another channel waits
    do_reset();
    push(0, 32'hDEADBEEF, 0);
    drive();
    wait_obs(2, 20);
    push(1, 32'h12345678, 0);
    drive();
    out_ready = 1'b0;
    cycle(); cycle(); cycle();
    out_ready = 1'b1;
    wait_obs(5, 20);
    check_seq("t2", 7'h6F, 7'h2B, 7'h37, 7'h6E, 7'h78, 0);
    check("t2_hold_cycles", hold37, 4);
    wait_idle(30);
    check("t2_total_slices", obs_d.size(), 10);

    // three channels streaming back to back
    do_reset();
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 3; c++) push(c, 32'hA5000000 + 32'(c * 16 + w), 0);
    drive();
    wait_idle(60);
    check_grants("t3", 0, 1, 2, 0);
    check("t3_grant4", (dgr.size() > 4) ? dgr[4] : -1, 1);
    check("t3_grant5", (dgr.size() > 5) ? dgr[5] : -1, 2);
    check("t3_valid_cycles", valid_cnt, 30);
    check("t3_no_bubble", last_v - first_v + 1, 30);

    // channel 1 disabled
    do_reset();
    cfg_chan_en = 4'b1101;
    push(0, 32'h11111111, 0); push(0, 32'h22222222, 0);
    push(1, 32'h33333333, 0); push(2, 32'h44444444, 0); push(3, 32'h55555555, 0);
    drive();
    wait_grants(4, 40);
    wait_idle(40);
    check_grants("t4", 0, 2, 3, 0);
    check("t4_ch1_ready", in1_cnt, 0);

    // reset mid-word, then a fresh word on channel 3
    do_reset();
    push(0, 32'hDEADBEEF, 0);
    drive();
    wait_obs(3, 20);
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) begin srcq[i].delete(); srcl[i].delete(); end
    drive();
    cycle(); cycle();
    rst_n = 1'b1;
    clear_obs();
    push(3, 32'h0000007F, 0);
    drive();
    wait_obs(5, 20);
    check_seq("t5", 7'h00, 7'h00, 7'h00, 7'h07, 7'h78, 3);
    wait_idle(20);

    // locked channel 2 against a competing channel 0
    do_reset();
    for (int w = 0; w < 3; w++) push(2, 32'hC0DE0000 + 32'(w), 1);
    drive();
    wait_grants(1, 10);
    for (int w = 0; w < 3; w++) push(0, 32'h0BAD0000 + 32'(w), 0);
    drive();
    wait_grants(4, 60);
`ifdef UNPACK_SCHED_LOCK_EN
    check_grants("t6", 2, 2, 2, 0);
`else
    check_grants("t6", 2, 0, 2, 0);
`endif
    wait_idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
